// File: rtl/spi_frame_parser.sv
// SPI write-frame parser: header, cmd, addr, len, payload[len] (+ checksum when
// SPI_FRAME_CHKSUM_EN is defined); accepted frames are replayed as register writes.
module spi_frame_parser #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [7:0]  CMD_WR  = 8'h01
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx_byte_valid,
  input  logic [7:0] rx_byte,
  input  logic       spi_cs,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int unsigned CW     = $clog2(MAX_LEN + 1);
  localparam int unsigned IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCmd     = 3'd1;
  localparam logic [2:0] StAddr    = 3'd2;
  localparam logic [2:0] StLen     = 3'd3;
  localparam logic [2:0] StPayload = 3'd4;
  localparam logic [2:0] StDrain   = 3'd6;
`ifdef SPI_FRAME_CHKSUM_EN
  localparam logic [2:0] StChk     = 3'd5;
  localparam logic [2:0] ErrChk    = 3'd3;
`endif

  localparam logic [2:0] ErrCmd     = 3'd1;
  localparam logic [2:0] ErrLen     = 3'd2;
  localparam logic [2:0] ErrAbort   = 3'd4;
  localparam logic [2:0] ErrOverrun = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]    buf_q [MAX_LEN];
  logic          buf_we;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          busy_q;
  logic          cs_s1_q, cs_s2_q, cs_s3_q;
  logic          abort, in_frame, last_byte;
`ifdef SPI_FRAME_CHKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // cs idles high, so the synchronizer resets high to avoid a false edge
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cs_s1_q <= 1'b1;
      cs_s2_q <= 1'b1;
      cs_s3_q <= 1'b1;
    end else begin
      cs_s1_q <= spi_cs;
      cs_s2_q <= cs_s1_q;
      cs_s3_q <= cs_s2_q;
    end
  end

  assign abort     = cs_s2_q & ~cs_s3_q;
  assign in_frame  = (state_q != StIdle) && (state_q != StDrain);
  assign cnt_inc   = cnt_q + CW'(1);
  assign last_byte = (cnt_q == len_q - CW'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    buf_we      = 1'b0;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
`ifdef SPI_FRAME_CHKSUM_EN
    sum_d       = sum_q;
`endif

    if (abort && in_frame) begin
      state_d     = StIdle;
      frame_err_d = 1'b1;
      err_code_d  = ErrAbort;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_byte_valid && (rx_byte == HEADER)) begin
            state_d = StCmd;
`ifdef SPI_FRAME_CHKSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end
        StCmd: begin
          if (rx_byte_valid) begin
            if (rx_byte == CMD_WR) begin
              state_d = StAddr;
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
              err_code_d  = ErrCmd;
            end
`ifdef SPI_FRAME_CHKSUM_EN
            sum_d = sum_q + rx_byte;
`endif
          end
        end
        StAddr: begin
          if (rx_byte_valid) begin
            addr_d  = rx_byte;
            state_d = StLen;
`ifdef SPI_FRAME_CHKSUM_EN
            sum_d   = sum_q + rx_byte;
`endif
          end
        end
        StLen: begin
          if (rx_byte_valid) begin
            if ((rx_byte != 8'd0) && (rx_byte <= MaxLen)) begin
              len_d   = CW'(rx_byte);
              cnt_d   = '0;
              state_d = StPayload;
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
              err_code_d  = ErrLen;
            end
`ifdef SPI_FRAME_CHKSUM_EN
            sum_d = sum_q + rx_byte;
`endif
          end
        end
        StPayload: begin
          if (rx_byte_valid) begin
            buf_we = 1'b1;
            cnt_d  = cnt_inc;
`ifdef SPI_FRAME_CHKSUM_EN
            sum_d  = sum_q + rx_byte;
            if (last_byte) state_d = StChk;
`else
            if (last_byte) begin
              state_d    = StDrain;
              cnt_d      = '0;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              // buf[0] is still being written when the frame is a single byte
              wr_data_d  = (cnt_q == '0) ? rx_byte : buf_q[0];
            end
`endif
          end
        end
`ifdef SPI_FRAME_CHKSUM_EN
        StChk: begin
          if (rx_byte_valid) begin
            if (rx_byte == sum_q) begin
              state_d    = StDrain;
              cnt_d      = '0;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = buf_q[0];
            end else begin
              state_d     = StIdle;
              frame_err_d = 1'b1;
              err_code_d  = ErrChk;
            end
          end
        end
`endif
        StDrain: begin
          if (rx_byte_valid) begin
            frame_err_d = 1'b1;
            err_code_d  = ErrOverrun;
          end
          if (wr_valid_q && wr_ready) begin
            if (last_byte) begin
              wr_valid_d = 1'b0;
              frame_ok_d = 1'b1;
              state_d    = StIdle;
            end else begin
              cnt_d     = cnt_inc;
              wr_addr_d = wr_addr_q + 8'd1;
              wr_data_d = buf_q[cnt_inc[IW-1:0]];
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (buf_we) buf_q[cnt_q[IW-1:0]] <= rx_byte;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= 8'd0;
      len_q       <= '0;
      cnt_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 3'd0;
      busy_q      <= 1'b0;
`ifdef SPI_FRAME_CHKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      busy_q      <= (state_d != StIdle);
`ifdef SPI_FRAME_CHKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_frame_parser.sv
// Bench for spi_frame_parser: frame-level reference model plus directed timing checks.
// Follows SPI_FRAME_CHKSUM_EN the same way the design does.
module tb_spi_frame_parser;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_byte_valid = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       spi_cs = 1'b1;
  logic       wr_ready = 1'b1;
  logic       wr_valid, frame_ok, frame_err, busy;
  logic [7:0] wr_addr, wr_data;
  logic [2:0] err_code;

`ifdef SPI_FRAME_CHKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  spi_frame_parser dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .rx_byte_valid (rx_byte_valid),
    .rx_byte       (rx_byte),
    .spi_cs        (spi_cs),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  stim[$];
  logic [15:0] exp_wr[$];
  int          exp_err[$];
  int          exp_ok = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: scan a byte stream frame by frame and list the outcomes it must produce.
  function automatic void model_stream();
    int i = 0;
    while (i < stim.size()) begin
      int len, need, s;
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= stim.size()) break;
      if (stim[i+1] != 8'h01) begin
        exp_err.push_back(1);
        i += 2;
        continue;
      end
      if (i + 3 >= stim.size()) break;
      len = int'(stim[i+3]);
      if (len == 0 || len > 16) begin
        exp_err.push_back(2);
        i += 4;
        continue;
      end
      need = 4 + len + (ChkEn ? 1 : 0);
      if (i + need > stim.size()) break;
      s = 1 + int'(stim[i+2]) + len;
      for (int k = 0; k < len; k++) s += int'(stim[i+4+k]);
      if (ChkEn && int'(stim[i+4+len]) != (s % 256)) begin
        exp_err.push_back(3);
      end else begin
        for (int k = 0; k < len; k++)
          exp_wr.push_back({8'((int'(stim[i+2]) + k) % 256), stim[i+4+k]});
        exp_ok++;
      end
      i += need;
    end
  endfunction

  task automatic pb(input logic [7:0] b);
    stim.push_back(b);
  endtask

  task automatic add_frame(input logic [7:0] a, input int n, input logic [7:0] seed);
    logic [7:0] s, d;
    pb(8'hA5); pb(8'h01); pb(a); pb(8'(n));
    s = 8'h01 + a + 8'(n);
    for (int k = 0; k < n; k++) begin
      d = seed + 8'(17 * k);
      pb(d);
      s = s + d;
    end
    if (ChkEn) pb(s);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  // Ends one ns after the edge that samples the last byte.
  task automatic run_stim();
    model_stream();
    foreach (stim[k]) begin
      if (k != 0) tick();
      send_byte(stim[k]);
    end
    stim.delete();
  endtask

  task automatic wait_idle(input int mode);
    int cyc = 0;
    while (cyc < 300) begin
      @(posedge sys_clk);
      #1;
      if (mode == 1) wr_ready = ((cyc % 3) != 1);
      @(negedge sys_clk);
      if (!busy && !wr_valid) break;
      cyc++;
    end
    #1 wr_ready = 1'b1;
    check("drain_done", 32'(busy), 32'd0);
  endtask

  // Per-cycle comparison against the model queues.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr, prev_data;
  always @(negedge sys_clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(wr_valid), 32'd1);
        check("hold_addr", 32'(wr_addr), 32'(prev_addr));
        check("hold_data", 32'(wr_data), 32'(prev_data));
      end
      if (wr_valid && wr_ready) begin
        check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          logic [15:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[15:8]));
          check("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
      end
      if (frame_err) begin
        check("err_expected", 32'(exp_err.size() > 0), 32'd1);
        if (exp_err.size() > 0) check("err_code", 32'(err_code), 32'(exp_err.pop_front()));
      end
      if (frame_ok) begin
        check("ok_expected", 32'(exp_ok > 0), 32'd1);
        if (exp_ok > 0) exp_ok--;
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int seen;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Good frame: A5 01 10 02 11 22 (46)
    add_frame(8'h10, 2, 8'h11);
    run_stim();
    @(negedge sys_clk);
    check("t1_valid0", 32'(wr_valid), 32'd1);
    check("t1_addr0", 32'(wr_addr), 32'h10);
    check("t1_data0", 32'(wr_data), 32'h11);
    @(negedge sys_clk);
    check("t1_addr1", 32'(wr_addr), 32'h11);
    check("t1_data1", 32'(wr_data), 32'h22);
    @(negedge sys_clk);
    check("t1_ok", 32'(frame_ok), 32'd1);
    check("t1_valid_end", 32'(wr_valid), 32'd0);
    @(negedge sys_clk);
    check("t1_ok_pulse", 32'(frame_ok), 32'd0);
    check("t1_err_code", 32'(err_code), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    tick();

    // Backpressure with address wrap FF -> 00
    add_frame(8'hFF, 2, 8'h11);
    wr_ready = 1'b0;
    run_stim();
    repeat (3) begin
      @(negedge sys_clk);
      check("t2_hold_valid", 32'(wr_valid), 32'd1);
      check("t2_hold_addr", 32'(wr_addr), 32'hFF);
      check("t2_hold_data", 32'(wr_data), 32'h11);
    end
    tick();
    wr_ready = 1'b1;
    @(negedge sys_clk);
    check("t2_pre_addr", 32'(wr_addr), 32'hFF);
    @(negedge sys_clk);
    check("t2_wrap_addr", 32'(wr_addr), 32'h00);
    check("t2_wrap_data", 32'(wr_data), 32'h22);
    wait_idle(0);
    tick();

`ifdef SPI_FRAME_CHKSUM_EN
    pb(8'hA5); pb(8'h01); pb(8'h10); pb(8'h02); pb(8'h11); pb(8'h22); pb(8'h47);
    run_stim();
    @(negedge sys_clk);
    check("t3_err", 32'(frame_err), 32'd1);
    check("t3_code", 32'(err_code), 32'd3);
    check("t3_valid", 32'(wr_valid), 32'd0);
    @(negedge sys_clk);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_err_pulse", 32'(frame_err), 32'd0);
    tick();
`endif

    // len = 0 followed by garbage
    pb(8'hA5); pb(8'h01); pb(8'h10); pb(8'h00); pb(8'h33); pb(8'h44);
    run_stim();
    @(negedge sys_clk);
    check("t4_len0_code", 32'(err_code), 32'd2);
    check("t4_len0_busy", 32'(busy), 32'd0);
    tick();
    pb(8'hA5); pb(8'h07);
    run_stim();
    @(negedge sys_clk);
    check("t4_cmd_code", 32'(err_code), 32'd1);
    tick();
    // len = MAX_LEN + 1
    pb(8'hA5); pb(8'h01); pb(8'h10); pb(8'h11); pb(8'h55);
    run_stim();
    @(negedge sys_clk);
    check("t4_len17_code", 32'(err_code), 32'd2);
    check("t4_len17_busy", 32'(busy), 32'd0);
    tick();
    // len = MAX_LEN wrapping past FF with ragged ready, then len = 1
    add_frame(8'hF8, 16, 8'h30);
    run_stim();
    wait_idle(1);
    tick();
    add_frame(8'h40, 1, 8'h5A);
    run_stim();
    wait_idle(0);
    tick();

    // CS abort mid-payload
    spi_cs = 1'b0;
    repeat (4) tick();
    pb(8'hA5); pb(8'h01); pb(8'h10); pb(8'h02); pb(8'h11);
    run_stim();
    exp_err.push_back(4);
    tick();
    spi_cs = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge sys_clk);
      if (frame_err) begin
        seen = 1;
        break;
      end
    end
    check("t5_abort_seen", 32'(seen), 32'd1);
    check("t5_code", 32'(err_code), 32'd4);
    check("t5_busy", 32'(busy), 32'd0);
    tick();
    add_frame(8'h20, 2, 8'h11);
    run_stim();
    wait_idle(0);
    check("t5_code_held", 32'(err_code), 32'd4);
    tick();

    // Overrun during a stalled drain
    add_frame(8'h10, 2, 8'h11);
    wr_ready = 1'b0;
    run_stim();
    tick();
    exp_err.push_back(5);
    send_byte(8'h55);
    @(negedge sys_clk);
    check("t6_err", 32'(frame_err), 32'd1);
    check("t6_code", 32'(err_code), 32'd5);
    check("t6_valid", 32'(wr_valid), 32'd1);
    tick();
    wr_ready = 1'b1;
    wait_idle(0);
    check("t6_code_held", 32'(err_code), 32'd5);
    tick();

    // Reset mid-frame
    send_byte(8'hA5);
    tick();
    send_byte(8'h01);
    tick();
    rst = 1'b1;
    @(negedge sys_clk);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_code", 32'(err_code), 32'd0);
    check("t7_rst_err", 32'(frame_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    add_frame(8'h80, 3, 8'h01);
    run_stim();
    wait_idle(0);

    repeat (3) tick();
    check("writes_left", 32'(exp_wr.size()), 32'd0);
    check("errs_left", 32'(exp_err.size()), 32'd0);
    check("oks_left", 32'(exp_ok), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_parser.md
# spi_frame_parser

Byte-level command parser placed directly downstream of the SPI slave receiver. It consumes the receiver's one-cycle byte-valid pulses and validates write-command frames of the form header, cmd, addr, len, payload[len] and an optional checksum. Each accepted frame is buffered and then replayed as a burst of register writes over a valid/ready port. Malformed or aborted frames are dropped and reported with an error code.

## Interface
- `MAX_LEN`, 16: payload buffer depth in bytes. Legal frame `len` is 1..MAX_LEN.
- `HEADER`, 8'hA5: frame start byte.
- `CMD_WR`, 8'h01: only accepted command.
- `sys_clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `rx_byte_valid` input 1: one-cycle pulse; `rx_byte` is valid in that cycle.
- `rx_byte` input 8: received byte.
- `spi_cs` input 1: raw active-low SPI chip select, asynchronous to `sys_clk`.
- `wr_valid` output 1: write request.
- `wr_addr` output 8: register address.
- `wr_data` output 8: register data.
- `wr_ready` input 1: consumer accepts the write when `wr_valid && wr_ready`.
- `frame_ok` output 1: one-cycle pulse when a frame has been fully written out.
- `frame_err` output 1: one-cycle pulse when a frame is dropped.
- `err_code` output 3: last error cause, held until the next `frame_err`.
- `busy` output 1: high in every state except IDLE.

## Operation
- **States:** IDLE, CMD, ADDR, LEN, PAYLOAD, CHK, DRAIN. Each state except DRAIN advances only on an `rx_byte_valid` cycle.
- **IDLE:**
  - Byte == HEADER: go to CMD and clear the running sum to 0.
  - Any other byte: discard silently, no error.
- **CMD:**
  - Byte == CMD_WR: go to ADDR.
  - Otherwise: error 1, go to IDLE.
- **ADDR:** latch the start address, go to LEN.
- **LEN:**
  - Byte in 1..MAX_LEN: latch it, clear the byte counter, go to PAYLOAD.
  - Otherwise: error 2, go to IDLE.
- **PAYLOAD:** store the byte at `buf[cnt]` and increment `cnt`. After byte number `len`, go to CHK.
- **Running sum:** 8-bit modulo-256 sum of the cmd, addr, len and all payload bytes.
- **CHK:**
  - Byte == sum: go to DRAIN.
  - Otherwise: error 3, go to IDLE.
- **DRAIN:**
  - Present `buf[i]` on `wr_data` with `wr_addr = start_addr + i`. The address wraps modulo 256 (addr 0xFF then 0x00).
  - Advance `i` only on handshake. `wr_valid`, `wr_addr` and `wr_data` stay stable while `wr_valid && !wr_ready`.
  - After the last handshake: pulse `frame_ok` next cycle and go to IDLE.
- **Overrun:** `rx_byte_valid` in DRAIN drops the byte and raises error 5 (`frame_err` pulse). The drain continues and still ends with `frame_ok`.
- **Abort:** `spi_cs` passes through a 2-flop synchronizer. A synchronized rising edge while in CMD, ADDR, LEN, PAYLOAD or CHK raises error 4 and returns to IDLE; buffer contents are discarded. The edge is ignored in IDLE and DRAIN.
- **Simultaneous events:** if the abort edge and `rx_byte_valid` fall in the same cycle, the abort wins and the byte is dropped.
- **Error codes:** 0 none (reset value), 1 bad cmd, 2 bad len, 3 checksum, 4 cs abort, 5 overrun.

## Timing
- **Reset values:** state IDLE; `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `frame_ok`=0, `frame_err`=0, `err_code`=0, `busy`=0.
- **Reset mid-frame or mid-drain:** return to IDLE immediately; no pulses are emitted.
- **State update:** the state register changes in the cycle after the `rx_byte_valid` cycle.
- **Final byte to first write:** the final byte (checksum, or last payload byte without checksum) in cycle N gives `wr_valid`=1 from N+1.
- **Burst throughput:** one write per cycle when `wr_ready` is held at 1. A `len`=L burst with `wr_ready`=1 occupies cycles N+1..N+L, with `frame_ok` at N+L+1.
- **Errors:** the offending byte in cycle N gives `frame_err`=1 and the updated `err_code` in N+1.
- **Abort latency:** a `spi_cs` rise is detected 3 `sys_clk` cycles after the pin changes (2 sync flops plus edge register).
- **`busy`:** a registered decode of state.

## Configuration
- Macro `SPI_FRAME_CHKSUM_EN`.
- **Defined:** CHK state present; frames carry a trailing checksum byte; error 3 is possible.
- **Undefined:**
  - CHK state and the sum logic are removed.
  - PAYLOAD goes directly to DRAIN after the last payload byte.
  - Error 3 never occurs.
  - All other behaviour is identical.

## Test plan
- **Good frame, checksum enabled:** frame A5 01 10 02 11 22 46 with `wr_ready`=1 -> writes (0x10,0x11) then (0x11,0x22) on consecutive cycles, then one `frame_ok` pulse, `err_code`=0.
- **Backpressure and wrap:** same frame with addr 0xFF and `wr_ready` low for 3 cycles -> `wr_valid`/addr 0xFF/data 0x11 held stable, then addr 0x00/data 0x22 written.
- **Bad checksum:** A5 01 10 02 11 22 47 -> no `wr_valid`, one `frame_err` pulse, `err_code`=3, `busy`=0.
- **Length errors:** `len`=0 and `len`=MAX_LEN+1 -> `err_code`=2 after the len byte, with the following bytes treated as IDLE garbage until the next A5.
- **CS abort:** `spi_cs` rise after A5 01 10 02 11 -> `err_code`=4, no writes; a following good frame is accepted normally.
- **Overrun:** extra byte 0x55 during a drain with `wr_ready`=0 -> `err_code`=5 pulse, both writes still complete, `frame_ok` pulses.
